// File: rtl/trace_buffer.sv
// ============================================================================
// Module   : trace_buffer
// Purpose  : First-word-fall-through capture buffer for retired-instruction
//            trace records, with sequence stamping and overflow accounting.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module trace_buffer #(
    parameter int DEPTH   = 16,
    parameter int IMM_W   = 12,
    parameter int MODE    = 0,
    localparam int ENTRY_W = 16 + 32 + 15 + 32 + IMM_W,
    localparam int CW      = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               capture_en,
    input  logic               trace_valid,
    input  logic [31:0]        trace_instruction,
    input  logic [4:0]         trace_rd,
    input  logic [4:0]         trace_rs1,
    input  logic [4:0]         trace_rs2,
    input  logic [31:0]        trace_rd_value,
    input  logic [IMM_W-1:0]   trace_imm,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ENTRY_W-1:0] out_entry,
    output logic [CW-1:0]      count,
    output logic               full,
    output logic               empty,
    output logic               overflow,
    output logic [15:0]        dropped
);

    localparam int            PW          = $clog2(DEPTH);
    localparam logic [CW-1:0] C_FULL_CNT  = CW'(DEPTH);
    localparam logic [15:0]   C_DROP_MAX  = 16'hFFFF;

    logic [ENTRY_W-1:0] mem_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [15:0]   seq_q, seq_d;
    logic [15:0]   dropped_q, dropped_d;
    logic          overflow_q, overflow_d;

    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic               w_wr_en;
    logic [ENTRY_W-1:0] w_entry;

    assign w_full  = (count_q == C_FULL_CNT);
    assign w_empty = (count_q == '0);
    assign w_push  = trace_valid && capture_en && !clear;
    assign w_pop   = !w_empty && out_ready && !clear;

    assign w_entry = {seq_q, trace_instruction, trace_rd, trace_rs1, trace_rs2,
                      trace_rd_value, trace_imm};

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        seq_d      = seq_q;
        dropped_d  = dropped_q;
        overflow_d = overflow_q;
        w_wr_en    = 1'b0;

        if (clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            seq_d      = '0;
            dropped_d  = '0;
            overflow_d = 1'b0;
        end else begin
            // A same-cycle pop frees the head slot, so a push into a full
            // buffer lands where the departing head was and becomes the tail.
            if (w_push && (w_pop || !w_full)) begin
                w_wr_en  = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
                seq_d    = seq_q + 1'b1;
                if (!w_pop) begin
                    count_d = count_q + 1'b1;
                end
            end else if (w_push) begin
                overflow_d = 1'b1;
                if (dropped_q != C_DROP_MAX) begin
                    dropped_d = dropped_q + 1'b1;
                end
                if (MODE == 1) begin
                    w_wr_en  = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    seq_d    = seq_q + 1'b1;
                end
            end

            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                if (!w_push) begin
                    count_d = count_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            seq_q      <= '0;
            dropped_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            seq_q      <= seq_d;
            dropped_q  <= dropped_d;
            overflow_q <= overflow_d;
        end
    end

    // Payload storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            mem_q[wr_ptr_q] <= w_entry;
        end
    end

    assign out_entry = mem_q[rd_ptr_q];
    assign out_valid = !w_empty;
    assign count     = count_q;
    assign full      = w_full;
    assign empty     = w_empty;
    assign overflow  = overflow_q;
    assign dropped   = dropped_q;

endmodule

`default_nettype wire

// File: tb/tb_trace_buffer.sv
// ============================================================================
// Module   : tb_trace_buffer
// Purpose  : Directed self-checking bench for trace_buffer, running a
//            drop-new (MODE 0) and an overwrite-oldest (MODE 1) instance.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_trace_buffer;

    localparam int DEPTH   = 4;
    localparam int IMM_W   = 12;
    localparam int ENTRY_W = 16 + 32 + 15 + 32 + IMM_W;
    localparam int CW      = $clog2(DEPTH) + 1;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               clear = 1'b0;
    logic               capture_en = 1'b0;
    logic               trace_valid = 1'b0;
    logic [31:0]        trace_instruction = '0;
    logic [4:0]         trace_rd = '0;
    logic [4:0]         trace_rs1 = '0;
    logic [4:0]         trace_rs2 = '0;
    logic [31:0]        trace_rd_value = '0;
    logic [IMM_W-1:0]   trace_imm = '0;
    logic               out_ready = 1'b0;

    logic               out_valid [2];
    logic [ENTRY_W-1:0] out_entry [2];
    logic [CW-1:0]      count     [2];
    logic               full      [2];
    logic               empty     [2];
    logic               overflow  [2];
    logic [15:0]        dropped   [2];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    trace_buffer #(.DEPTH(DEPTH), .IMM_W(IMM_W), .MODE(0)) u_dut0 (
        .clk(clk), .rst(rst), .clear(clear), .capture_en(capture_en),
        .trace_valid(trace_valid), .trace_instruction(trace_instruction),
        .trace_rd(trace_rd), .trace_rs1(trace_rs1), .trace_rs2(trace_rs2),
        .trace_rd_value(trace_rd_value), .trace_imm(trace_imm),
        .out_valid(out_valid[0]), .out_ready(out_ready), .out_entry(out_entry[0]),
        .count(count[0]), .full(full[0]), .empty(empty[0]),
        .overflow(overflow[0]), .dropped(dropped[0])
    );

    trace_buffer #(.DEPTH(DEPTH), .IMM_W(IMM_W), .MODE(1)) u_dut1 (
        .clk(clk), .rst(rst), .clear(clear), .capture_en(capture_en),
        .trace_valid(trace_valid), .trace_instruction(trace_instruction),
        .trace_rd(trace_rd), .trace_rs1(trace_rs1), .trace_rs2(trace_rs2),
        .trace_rd_value(trace_rd_value), .trace_imm(trace_imm),
        .out_valid(out_valid[1]), .out_ready(out_ready), .out_entry(out_entry[1]),
        .count(count[1]), .full(full[1]), .empty(empty[1]),
        .overflow(overflow[1]), .dropped(dropped[1])
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rec(input logic [31:0] ins);
        trace_instruction = ins;
        trace_rd          = ins[11:7];
        trace_rs1         = ins[19:15];
        trace_rs2         = ins[24:20];
        trace_rd_value    = ~ins;
        trace_imm         = ins[31:20];
    endtask

    task automatic push_rec(input logic [31:0] ins);
        set_rec(ins);
        trace_valid = 1'b1;
        capture_en  = 1'b1;
        step();
        trace_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        for (int d = 0; d < 2; d++) begin
            n_vec++;
            if (count[d] !== 3'd0 || out_valid[d] !== 1'b0 || empty[d] !== 1'b1 || full[d] !== 1'b0) begin
                n_err++;
                $display("FAIL reset_state dut%0d: count=%0d valid=%b empty=%b full=%b, want 0/0/1/0",
                         d, count[d], out_valid[d], empty[d], full[d]);
            end
            n_vec++;
            if (overflow[d] !== 1'b0 || dropped[d] !== 16'd0) begin
                n_err++;
                $display("FAIL reset_ovf dut%0d: overflow=%b dropped=%0d, want 0/0", d, overflow[d], dropped[d]);
            end
        end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_in_order();
        logic [31:0]        ins [3];
        logic [ENTRY_W-1:0] exp;
        ins[0] = 32'h00500093;
        ins[1] = 32'h00A00113;
        ins[2] = 32'h002081B3;
        push_rec(ins[0]);
        for (int d = 0; d < 2; d++) begin
            n_vec++;
            if (out_valid[d] !== 1'b1) begin
                n_err++;
                $display("FAIL push_latency dut%0d: out_valid=%b, want 1", d, out_valid[d]);
            end
        end
        push_rec(ins[1]);
        push_rec(ins[2]);
        for (int d = 0; d < 2; d++) begin
            n_vec++;
            if (count[d] !== 3'd3) begin
                n_err++;
                $display("FAIL inorder_count dut%0d: count=%0d, want 3", d, count[d]);
            end
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp = {16'(i), ins[i], ins[i][11:7], ins[i][19:15], ins[i][24:20], ~ins[i], ins[i][31:20]};
            for (int d = 0; d < 2; d++) begin
                n_vec++;
                if (out_valid[d] !== 1'b1 || out_entry[d] !== exp) begin
                    n_err++;
                    $display("FAIL inorder_entry%0d dut%0d: valid=%b entry=%h, want 1/%h",
                             i, d, out_valid[d], out_entry[d], exp);
                end
            end
            step();
        end
        out_ready = 1'b0;
        for (int d = 0; d < 2; d++) begin
            n_vec++;
            if (empty[d] !== 1'b1 || count[d] !== 3'd0) begin
                n_err++;
                $display("FAIL inorder_empty dut%0d: empty=%b count=%0d, want 1/0", d, empty[d], count[d]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [15:0] exp_seq;
        do_clear();
        for (int i = 0; i < 6; i++) push_rec(32'h1000 + 32'(i));
        for (int d = 0; d < 2; d++) begin
            n_vec++;
            if (count[d] !== 3'd4 || full[d] !== 1'b1 || overflow[d] !== 1'b1 || dropped[d] !== 16'd2) begin
                n_err++;
                $display("FAIL ovf_state dut%0d: count=%0d full=%b ovf=%b dropped=%0d, want 4/1/1/2",
                         d, count[d], full[d], overflow[d], dropped[d]);
            end
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            for (int d = 0; d < 2; d++) begin
                exp_seq = (d == 0) ? 16'(i) : 16'(i + 2);
                n_vec++;
                if (out_entry[d][106:91] !== exp_seq || out_entry[d][90:59] !== 32'h1000 + 32'(exp_seq)) begin
                    n_err++;
                    $display("FAIL ovf_drain%0d dut%0d: seq=%0d ins=%h, want %0d/%h", i, d,
                             out_entry[d][106:91], out_entry[d][90:59], exp_seq, 32'h1000 + 32'(exp_seq));
                end
            end
            step();
        end
        out_ready = 1'b0;
        for (int d = 0; d < 2; d++) begin
            n_vec++;
            if (empty[d] !== 1'b1 || overflow[d] !== 1'b1) begin
                n_err++;
                $display("FAIL ovf_sticky dut%0d: empty=%b ovf=%b, want 1/1", d, empty[d], overflow[d]);
            end
        end
        do_clear();
        for (int d = 0; d < 2; d++) begin
            n_vec++;
            if (overflow[d] !== 1'b0 || dropped[d] !== 16'd0) begin
                n_err++;
                $display("FAIL clear_ovf dut%0d: ovf=%b dropped=%0d, want 0/0", d, overflow[d], dropped[d]);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_clear();
        for (int i = 0; i < 4; i++) push_rec(32'h2000 + 32'(i));
        set_rec(32'hCAFE0013);
        trace_valid = 1'b1;
        capture_en  = 1'b1;
        out_ready   = 1'b1;
        for (int d = 0; d < 2; d++) begin
            n_vec++;
            if (full[d] !== 1'b1 || out_entry[d][106:91] !== 16'd0) begin
                n_err++;
                $display("FAIL b2b_pre dut%0d: full=%b head_seq=%0d, want 1/0", d, full[d], out_entry[d][106:91]);
            end
        end
        step();
        trace_valid = 1'b0;
        for (int d = 0; d < 2; d++) begin
            n_vec++;
            if (count[d] !== 3'd4 || overflow[d] !== 1'b0 || dropped[d] !== 16'd0) begin
                n_err++;
                $display("FAIL b2b_state dut%0d: count=%0d ovf=%b dropped=%0d, want 4/0/0",
                         d, count[d], overflow[d], dropped[d]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            for (int d = 0; d < 2; d++) begin
                n_vec++;
                if (out_entry[d][106:91] !== 16'(i + 1)) begin
                    n_err++;
                    $display("FAIL b2b_drain%0d dut%0d: seq=%0d, want %0d", i, d, out_entry[d][106:91], i + 1);
                end
            end
            if (i == 3) begin
                for (int d = 0; d < 2; d++) begin
                    n_vec++;
                    if (out_entry[d][90:59] !== 32'hCAFE0013) begin
                        n_err++;
                        $display("FAIL b2b_last dut%0d: ins=%h, want cafe0013", d, out_entry[d][90:59]);
                    end
                end
            end
            step();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        do_clear();
        for (int i = 0; i < 3; i++) push_rec(32'h3000 + 32'(i));
        #2;
        rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            n_vec++;
            if (count[d] !== 3'd0 || out_valid[d] !== 1'b0 || empty[d] !== 1'b1) begin
                n_err++;
                $display("FAIL async_rst dut%0d: count=%0d valid=%b empty=%b, want 0/0/1",
                         d, count[d], out_valid[d], empty[d]);
            end
        end
        rst = 1'b0;
        step();
        push_rec(32'h3333);
        for (int d = 0; d < 2; d++) begin
            n_vec++;
            if (count[d] !== 3'd1 || out_entry[d][106:91] !== 16'd0 || out_entry[d][90:59] !== 32'h3333) begin
                n_err++;
                $display("FAIL rst_seq dut%0d: count=%0d seq=%0d ins=%h, want 1/0/00003333",
                         d, count[d], out_entry[d][106:91], out_entry[d][90:59]);
            end
        end
    endtask

    task automatic test_capture_gate();
        do_clear();
        set_rec(32'h4444);
        capture_en  = 1'b0;
        trace_valid = 1'b1;
        repeat (5) step();
        trace_valid = 1'b0;
        for (int d = 0; d < 2; d++) begin
            n_vec++;
            if (count[d] !== 3'd0) begin
                n_err++;
                $display("FAIL gate_count dut%0d: count=%0d, want 0", d, count[d]);
            end
        end
        out_ready = 1'b1;
        repeat (2) step();
        out_ready = 1'b0;
        for (int d = 0; d < 2; d++) begin
            n_vec++;
            if (count[d] !== 3'd0 || empty[d] !== 1'b1) begin
                n_err++;
                $display("FAIL empty_pop dut%0d: count=%0d empty=%b, want 0/1", d, count[d], empty[d]);
            end
        end
        push_rec(32'h5555);
        for (int d = 0; d < 2; d++) begin
            n_vec++;
            if (count[d] !== 3'd1 || out_entry[d][106:91] !== 16'd0) begin
                n_err++;
                $display("FAIL gate_seq dut%0d: count=%0d seq=%0d, want 1/0", d, count[d], out_entry[d][106:91]);
            end
        end
        set_rec(32'h6666);
        trace_valid = 1'b1;
        capture_en  = 1'b1;
        clear       = 1'b1;
        step();
        clear       = 1'b0;
        trace_valid = 1'b0;
        for (int d = 0; d < 2; d++) begin
            n_vec++;
            if (count[d] !== 3'd0 || out_valid[d] !== 1'b0) begin
                n_err++;
                $display("FAIL clear_push dut%0d: count=%0d valid=%b, want 0/0", d, count[d], out_valid[d]);
            end
        end
        push_rec(32'h7777);
        for (int d = 0; d < 2; d++) begin
            n_vec++;
            if (out_entry[d][106:91] !== 16'd0 || out_entry[d][90:59] !== 32'h7777) begin
                n_err++;
                $display("FAIL clear_seq dut%0d: seq=%0d ins=%h, want 0/00007777",
                         d, out_entry[d][106:91], out_entry[d][90:59]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_overflow();
        test_back_to_back();
        test_async_reset();
        test_capture_gate();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/trace_buffer.md
TRACE_BUFFER -- requirements
Module: trace_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16; entry capacity; power of two, 2..1024.
REQ-002 SHALL have parameter IMM_W, default 12; width of trace_imm.
REQ-003 SHALL have parameter MODE, default 0; 0 = stop-on-full (drop new), 1 = overwrite-oldest.
REQ-004 SHALL have local ENTRY_W = 16 + 32 + 15 + 32 + IMM_W; CW = $clog2(DEPTH)+1.
REQ-005 SHALL have port clk, input, 1; single rising-edge clock.
REQ-006 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-007 SHALL have port clear, input, 1; synchronous flush of contents and counters.
REQ-008 SHALL have port capture_en, input, 1; gates acceptance of trace_valid.
REQ-009 SHALL have port trace_valid, input, 1; one retired instruction presented this cycle.
REQ-010 SHALL have ports trace_instruction (32), trace_rd (5), trace_rs1 (5), trace_rs2 (5), trace_rd_value (32), trace_imm (IMM_W), all inputs; retired-instruction record.
REQ-011 SHALL have port out_valid, output, 1; head entry available.
REQ-012 SHALL have port out_ready, input, 1; consumer accepts head.
REQ-013 SHALL have port out_entry, output, ENTRY_W; packed {seq[15:0], instruction, rd, rs1, rs2, rd_value, imm}, MSB first.
REQ-014 SHALL have ports count (CW), full (1), empty (1), overflow (1), dropped (16), all outputs.

Function
REQ-015 SHALL accept a push when trace_valid && capture_en && !clear.
REQ-016 SHALL pop when out_valid && out_ready && !clear.
REQ-017 SHALL present out_entry = storage[rd_ptr] combinationally (first-word fall-through); out_valid = !empty.
REQ-018 SHALL have push-to-out_valid latency of exactly one cycle from an empty buffer.
REQ-019 SHALL stamp each accepted entry with seq, a 16-bit counter incremented per accepted push, wrapping 0xFFFF -> 0x0000.
REQ-020 SHALL, when not full, on push write at wr_ptr and increment wr_ptr modulo DEPTH and count by one.
REQ-021 SHALL, on simultaneous push and pop, leave count unchanged and advance both pointers, including when full, in both modes.
REQ-022 SHALL, in MODE 0 when full with push and no pop, discard the new record, keep seq unchanged, set overflow, and increment dropped.
REQ-023 SHALL, in MODE 1 when full with push and no pop, write the new record, advance both pointers, keep count = DEPTH, set overflow, increment dropped, and advance seq.
REQ-024 SHALL make a pop while empty a no-op.
REQ-025 SHALL saturate dropped at 0xFFFF; overflow SHALL be sticky until rst or clear.
REQ-026 SHALL drive full = (count == DEPTH) and empty = (count == 0) from registered count.
REQ-027 SHALL, on clear, zero pointers, count, seq, overflow and dropped on the next edge, ignoring same-cycle push/pop.
REQ-028 SHALL ignore trace record fields when trace_valid is 0.

Reset
REQ-029 SHALL, on rst assertion, immediately zero pointers, count, seq, overflow and dropped regardless of clk; out_valid=0, empty=1, full=0.
REQ-030 SHALL NOT require storage array reset; out_entry is don't-care while out_valid=0.
REQ-031 SHALL, on rst asserted mid-stream, lose all entries; the first push after release SHALL carry seq=0.

Verification
REQ-032 SHALL cover: DEPTH=4, 3 pushes with instruction 0x00500093, 0x00A00113, 0x002081B3, out_ready=0 -> count=3; then out_ready=1 -> entries drain in order with seq 0,1,2; empty=1 after the third pop.
REQ-033 SHALL cover: MODE=0, DEPTH=4, 6 pushes, no pops -> count=4, overflow=1, dropped=2; drain yields seq 0..3.
REQ-034 SHALL cover: MODE=1, DEPTH=4, 6 pushes, no pops -> count=4, dropped=2; drain yields seq 2..5.
REQ-035 SHALL cover: full buffer with push and pop in the same cycle -> count stays 4, overflow unchanged, new entry is last out.
REQ-036 SHALL cover: rst pulsed between clock edges with count=3 -> count=0 and out_valid=0 before the next edge; next push carries seq=0.
REQ-037 SHALL cover: capture_en=0 with trace_valid=1 for 5 cycles -> count=0 and seq unchanged; clear with push pending -> count=0 next cycle.
